// File: rtl/stopwatch_ctrl_if.sv
// Signal bundle between the stopwatch core and the board top level:
// raw active-low keys in, MM:SS BCD digits and status out.
interface stopwatch_ctrl_if;
  logic       key_start_n;
  logic       key_reset_n;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] min_ones;
  logic [3:0] min_tens;
  logic       running;
  logic [1:0] state;
  logic       tick;
  logic       wrap;

  modport master (
    output key_start_n, key_reset_n,
    input  sec_ones, sec_tens, min_ones, min_tens, running, state, tick, wrap
  );

  modport slave (
    input  key_start_n, key_reset_n,
    output sec_ones, sec_tens, min_ones, min_tens, running, state, tick, wrap
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch core: key synchronise/debounce, IDLE/RUN/PAUSED control,
// 1 Hz prescaler and MM:SS BCD counter with registered outputs.
module stopwatch_ctrl #(
  parameter int CLK_HZ          = 50000000,
  parameter int TICK_HZ         = 1,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic             CLOCK_50,
  input  logic             RESET_N,
  stopwatch_ctrl_if.slave  io_sw
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int DW  = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
  localparam logic [PW-1:0] PRE_ONE  = PW'(1);
  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DB_ONE   = DW'(1);

  if (DIV < 2) begin : g_divCheck
    $error("stopwatch_ctrl: CLK_HZ/TICK_HZ must be at least 2");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_dbCheck
    $error("stopwatch_ctrl: DEBOUNCE_CYCLES must be at least 2");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_PAUSED = 2'b10
  } state_t;

  // Bit 0 is Start/Pause, bit 1 is Reset.
  logic [1:0]    w_keyRaw;
  logic [1:0]    r_sync1;
  logic [1:0]    r_sync2;
  logic [1:0]    r_deb;
  logic [1:0]    r_debLast;
  logic [1:0]    r_press;
  logic [DW-1:0] r_dbCnt [2];
  logic          w_startPress;
  logic          w_resetPress;

  state_t        r_state;
  logic          r_running;
  logic [PW-1:0] r_presc;
  logic          r_tick;
  logic          r_wrap;
  logic [3:0]    r_secOnes;
  logic [3:0]    r_secTens;
  logic [3:0]    r_minOnes;
  logic [3:0]    r_minTens;

  assign w_keyRaw     = {io_sw.key_reset_n, io_sw.key_start_n};
  assign w_startPress = r_press[0];
  assign w_resetPress = r_press[1];

  // Press pulse is taken from a delayed copy of the debounced level so the
  // key-to-action latency is a fixed DEBOUNCE_CYCLES+3 edges.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_sync1   <= 2'b11;
      r_sync2   <= 2'b11;
      r_deb     <= 2'b11;
      r_debLast <= 2'b11;
      r_press   <= 2'b00;
      for (int i = 0; i < 2; i++) r_dbCnt[i] <= '0;
    end else begin
      r_sync1   <= w_keyRaw;
      r_sync2   <= r_sync1;
      r_debLast <= r_deb;
      r_press   <= r_debLast & ~r_deb;
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_dbCnt[i] <= '0;
        end else if (r_dbCnt[i] == DB_LAST) begin
          r_deb[i]   <= r_sync2[i];
          r_dbCnt[i] <= '0;
        end else begin
          r_dbCnt[i] <= r_dbCnt[i] + DB_ONE;
        end
      end
    end
  end

  // The prescaler keeps counting on the RUN->PAUSED edge, so a pause landing
  // on terminal count still advances the digits before freezing.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state   <= S_IDLE;
      r_running <= 1'b0;
      r_presc   <= '0;
      r_tick    <= 1'b0;
      r_wrap    <= 1'b0;
      r_secOnes <= 4'd0;
      r_secTens <= 4'd0;
      r_minOnes <= 4'd0;
      r_minTens <= 4'd0;
    end else begin
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
      if (w_resetPress) begin
        r_state   <= S_IDLE;
        r_running <= 1'b0;
        r_presc   <= '0;
        r_secOnes <= 4'd0;
        r_secTens <= 4'd0;
        r_minOnes <= 4'd0;
        r_minTens <= 4'd0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_startPress) begin
              r_state   <= S_RUN;
              r_running <= 1'b1;
              r_presc   <= '0;
            end
          end
          S_RUN: begin
            if (w_startPress) begin
              r_state   <= S_PAUSED;
              r_running <= 1'b0;
            end
            if (r_presc == PRE_LAST) begin
              r_presc <= '0;
              r_tick  <= 1'b1;
              if (r_secOnes != 4'd9) begin
                r_secOnes <= r_secOnes + 4'd1;
              end else begin
                r_secOnes <= 4'd0;
                if (r_secTens != 4'd5) begin
                  r_secTens <= r_secTens + 4'd1;
                end else begin
                  r_secTens <= 4'd0;
                  if (r_minOnes != 4'd9) begin
                    r_minOnes <= r_minOnes + 4'd1;
                  end else begin
                    r_minOnes <= 4'd0;
                    if (r_minTens != 4'd5) begin
                      r_minTens <= r_minTens + 4'd1;
                    end else begin
                      r_minTens <= 4'd0;
                      r_wrap    <= 1'b1;
                    end
                  end
                end
              end
            end else begin
              r_presc <= r_presc + PRE_ONE;
            end
          end
          S_PAUSED: begin
            if (w_startPress) begin
              r_state   <= S_RUN;
              r_running <= 1'b1;
            end
          end
          default: begin
            r_state   <= S_IDLE;
            r_running <= 1'b0;
            r_presc   <= '0;
            r_secOnes <= 4'd0;
            r_secTens <= 4'd0;
            r_minOnes <= 4'd0;
            r_minTens <= 4'd0;
          end
        endcase
      end
    end
  end

  assign io_sw.sec_ones = r_secOnes;
  assign io_sw.sec_tens = r_secTens;
  assign io_sw.min_ones = r_minOnes;
  assign io_sw.min_tens = r_minTens;
  assign io_sw.running  = r_running;
  assign io_sw.state    = r_state;
  assign io_sw.tick     = r_tick;
  assign io_sw.wrap     = r_wrap;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DIV=10 and DEBOUNCE_CYCLES=4;
// inputs change and outputs are sampled on the falling clock edge.
module tb_stopwatch_ctrl;
  localparam int CLK_HZ          = 10;
  localparam int TICK_HZ         = 1;
  localparam int DEBOUNCE_CYCLES = 4;

  logic clk    = 1'b0;
  logic resetN = 1'b0;
  int   testsRun  = 0;
  int   failCount = 0;

  stopwatch_ctrl_if sw ();

  stopwatch_ctrl #(
    .CLK_HZ          (CLK_HZ),
    .TICK_HZ         (TICK_HZ),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) dut (
    .CLOCK_50 (clk),
    .RESET_N  (resetN),
    .io_sw    (sw.slave)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic startN, input logic resetKeyN);
    sw.key_start_n = startN;
    sw.key_reset_n = resetKeyN;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [15:0] digits();
    return {sw.min_tens, sw.min_ones, sw.sec_tens, sw.sec_ones};
  endfunction

  function automatic logic [20:0] allOutputs();
    return {sw.state, sw.running, sw.tick, sw.wrap, digits()};
  endfunction

  initial begin
    #1_000_000;
    $display("[TB] FAIL timeout: run still active, required summary before 100000 cycles");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin
    applyStimulus(1'b1, 1'b1);
    waitCycles(3);
    checkOutput("resetState", 32'(allOutputs()), 32'd0);
    resetN = 1'b1;
    waitCycles(5);
    checkOutput("idleAfterRelease", 32'(allOutputs()), 32'd0);

    // Start, run to 00:03, pause at prescaler 4, resume, run to 00:07.
    applyStimulus(1'b0, 1'b1);
    for (int i = 1; i <= 137; i++) begin
      logic [1:0] expState;
      logic       expTick;
      logic [3:0] expSec;
      waitCycles(1);
      expState = (i < 8) ? 2'd0 : (i < 42) ? 2'd1 : (i < 100) ? 2'd2 : 2'd1;
      expTick  = (i == 18) || (i == 28) || (i == 38) || (i == 106) ||
                 (i == 116) || (i == 126) || (i == 136);
      expSec   = (i < 18) ? 4'd0 : (i < 28) ? 4'd1 : (i < 38) ? 4'd2 :
                 (i < 106) ? 4'd3 : (i < 116) ? 4'd4 : (i < 126) ? 4'd5 :
                 (i < 136) ? 4'd6 : 4'd7;
      checkOutput("runState", 32'({sw.state, sw.running}), 32'({expState, expState == 2'd1}));
      checkOutput("runTick", 32'(sw.tick), 32'(expTick));
      checkOutput("runDigits", 32'(digits()), 32'({12'h000, expSec}));
      if (i == 20 || i == 44 || i == 102) applyStimulus(1'b1, 1'b1);
      if (i == 34 || i == 92) applyStimulus(1'b0, 1'b1);
    end

    waitCycles(1);
    resetN = 1'b0;
    #1;
    checkOutput("asyncReset", 32'(allOutputs()), 32'd0);
    waitCycles(2);
    resetN = 1'b1;
    for (int i = 0; i < 100; i++) begin
      waitCycles(1);
      checkOutput("quietAfterReset", 32'(allOutputs()), 32'd0);
    end

    // A 3-cycle glitch must be ignored; a 6-cycle one starts the watch once.
    applyStimulus(1'b0, 1'b1);
    waitCycles(3);
    applyStimulus(1'b1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      waitCycles(1);
      checkOutput("shortGlitch", 32'({sw.state, sw.tick}), 32'd0);
    end
    applyStimulus(1'b0, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      waitCycles(1);
      checkOutput("longGlitch", 32'(sw.state), (i < 8) ? 32'd0 : 32'd1);
      if (i == 6) applyStimulus(1'b1, 1'b1);
    end

    // Every tick through the 59:59 wrap and on to 12:34.
    for (int t = 1; t <= 4354; t++) begin
      int s;
      int mm;
      int ss;
      waitCycles(10);
      s  = t % 3600;
      mm = s / 60;
      ss = s % 60;
      checkOutput((t == 3600) ? "wrap5959" : "countTick",
                  32'({digits(), sw.tick, sw.wrap}),
                  32'({4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10),
                       1'b1, 1'(t == 3600)}));
    end

    applyStimulus(1'b0, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      waitCycles(1);
      checkOutput("pauseAt1234", 32'(sw.state), (i < 8) ? 32'd1 : 32'd2);
    end
    checkOutput("frozen1234", 32'({digits(), sw.tick}), 32'({16'h1234, 1'b0}));
    waitCycles(2);
    applyStimulus(1'b1, 1'b1);
    waitCycles(20);

    // Start and reset together from PAUSED: reset wins.
    applyStimulus(1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      waitCycles(1);
      if (i == 7) checkOutput("bothBefore", 32'({sw.state, digits()}), 32'({2'd2, 16'h1234}));
      if (i == 8) checkOutput("bothReset", 32'(allOutputs()), 32'd0);
    end
    waitCycles(2);
    applyStimulus(1'b1, 1'b1);
    waitCycles(20);

    applyStimulus(1'b0, 1'b1);
    for (int i = 1; i <= 18; i++) begin
      waitCycles(1);
      checkOutput("restartState", 32'(sw.state), (i < 8) ? 32'd0 : 32'd1);
      checkOutput("restartTick", 32'({sw.tick, digits()}),
                  (i == 18) ? 32'({1'b1, 16'h0001}) : 32'd0);
      if (i == 10) applyStimulus(1'b1, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Control and timebase core for the DE10-Lite stopwatch. Sits between the raw KEY inputs and the four HEX digit decoders.
- Debounces Start/Pause and Reset, runs the IDLE/RUN/PAUSED state machine and divides CLOCK_50 into a 1 Hz count enable.
- Holds the MM:SS BCD count that the top level feeds to the 7-segment decoders.

Parameters:
- CLK_HZ, 50000000, input clock frequency in Hz.
- TICK_HZ, 1, count rate in Hz. DIV = CLK_HZ/TICK_HZ; elaboration error if DIV < 2.
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles (20 ms at 50 MHz) required before a key level is accepted; must be >= 2.

Ports:
- CLOCK_50  in  1  single clock, all logic on rising edge.
- RESET_N  in  1  asynchronous active-low reset; release is synchronous to CLOCK_50.
- key_start_n  in  1  raw KEY[0], active-low Start/Pause, asynchronous to the clock.
- key_reset_n  in  1  raw KEY[1], active-low Reset, asynchronous to the clock.
- sec_ones  out  4  BCD seconds ones, 0-9.
- sec_tens  out  4  BCD seconds tens, 0-5.
- min_ones  out  4  BCD minutes ones, 0-9.
- min_tens  out  4  BCD minutes tens, 0-5.
- running  out  1  high while in the RUN state.
- state  out  2  00=IDLE, 01=RUN, 10=PAUSED; 11 is never produced.
- tick  out  1  one-cycle pulse, high in the cycle the count advances.
- wrap  out  1  one-cycle pulse, high in the cycle the count rolls 59:59 -> 00:00.

Behaviour:
- Reset (RESET_N low): every output is 0 and state is IDLE. Also cleared: prescaler, debounce counters and press pulses. Synchronizer flops and debounced levels are set to 1 (released).
- Input path, per key:
  - 2-flop synchronizer.
  - Debounce counter clears whenever the synchronized level equals the debounced level. Otherwise it increments; when it reaches DEBOUNCE_CYCLES-1 the debounced level takes the synchronized level and the counter clears.
  - The press pulse (registered) is high for one cycle after the debounced level falls 1->0. Releases generate no event.
  - A glitch shorter than DEBOUNCE_CYCLES cycles produces no event.
- Latency: raw key low first sampled at edge k -> state/count change visible after edge k+DEBOUNCE_CYCLES+3. This is fixed and exact.
- FSM, evaluated on each edge:
  - Any state, reset press: go to IDLE; clear BCD digits and prescaler. Reset press has priority over a start press in the same cycle.
  - IDLE, start press: go to RUN; prescaler starts at 0.
  - RUN, start press: go to PAUSED; prescaler and digits freeze at their current values.
  - PAUSED, start press: go to RUN; prescaler resumes from its frozen value, so the sub-second fraction is preserved.
  - Holding a key generates only one event.
- Prescaler:
  - Counts 0..DIV-1, only in RUN. At DIV-1 it reloads to 0 and the BCD count advances by 1 on the same edge.
  - tick is high during the following cycle, coincident with the new digit values.
  - If a start press (RUN->PAUSED) lands on the terminal-count edge, the advance still occurs and then the prescaler freezes at 0.
- BCD arithmetic:
  - sec_ones carries 9->0 into sec_tens.
  - sec_tens carries 5->0 into min_ones.
  - min_ones carries 9->0 into min_tens.
  - min_tens wraps 5->0. 59:59 -> 00:00 asserts wrap together with tick, and counting continues.
- Unreachable state 11 recovers to IDLE with counters cleared.
- Outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Bench parameters: CLK_HZ=10, TICK_HZ=1, DEBOUNCE_CYCLES=4, so DIV=10.
- Assert RESET_N low mid-run at count 00:07 -> all outputs 0 and state=00 immediately (asynchronous); after release with no keys pressed, they remain 0 for 100 cycles.
- Start press held 20 cycles, low first sampled at edge k -> state=01 after edge k+7. tick pulses every 10 cycles. After 30 cycles in RUN, sec_ones=3 and sec_tens=0. Key release produces no event.
- Pause then resume:
  - Pause at prescaler=4 -> digits frozen and no tick for 50 cycles; state=10.
  - Resume -> first tick exactly 6 cycles after the state returns to 01.
- Glitch: key_start_n low for 3 cycles, then high -> no state change and no tick. Glitch low for 6 cycles -> exactly one start event.
- Preload by running 3599 ticks to 59:59 -> next tick gives 00:00 with wrap=1 and tick=1 in the same cycle; 9->0 and 5->0 carries are checked at 00:09->00:10, 00:59->01:00 and 09:59->10:00.
- Start and reset pressed in the same cycle while in PAUSED at 12:34 -> state=IDLE, all digits 0, running=0. A start press alone then enters RUN from 00:00.
